// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings and FSM state type shared by the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, load extraction/extension, legality checks
// Misalignment reporting is compiled in only with LSU_MISALIGN_CHK_EN.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] prdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        illegal,
  output logic        misalign
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = 32'h0;
    if (st_we) begin
      case (st_funct3)
        F3_SB: begin
          st_strb  = 4'b0001 << st_off;
          st_wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          st_strb  = 4'b0011 << {st_off[1], 1'b0};
          st_wdata = {2{store_data[15:0]}};
        end
        F3_SW: begin
          st_strb  = 4'b1111;
          st_wdata = store_data;
        end
        default: ;
      endcase
    end
  end

  // Halves ignore off[0] and words ignore off entirely when unaligned accesses are let through.
  assign ld_byte = prdata[{ld_off, 3'b000} +: 8];
  assign ld_half = prdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data = prdata;
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

  assign illegal = st_we ? (st_funct3 > 3'd2)
                         : ((st_funct3 == 3'd3) || (st_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    misalign = 1'b0;
    case (st_funct3[1:0])
      2'b01:   misalign = st_off[0];
      2'b10:   misalign = (st_off != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu_apb.sv
// rtl/lsu_apb.sv - single-outstanding APB4 master load/store unit behind the execute stage
module lsu_apb
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] alu_data,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int              CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      st_strb;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_data;
  logic            illegal, misalign, reject;
  logic            take, done, abort;

  lsu_align u_align (
    .st_we      (req_we),
    .st_funct3  (req_funct3),
    .st_off     (alu_data[1:0]),
    .store_data (store_data),
    .ld_funct3  (funct3_q),
    .ld_off     (off_q),
    .prdata     (prdata),
    .st_strb    (st_strb),
    .st_wdata   (st_wdata),
    .ld_data    (ld_data),
    .illegal    (illegal),
    .misalign   (misalign)
  );

  assign reject    = illegal | misalign;
  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          take      = !reject;
          state_nxt = reject ? ERR : SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == LIMIT)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/strobe/data are captured once at accept so the bus stays stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      pstrb     <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= 1'b0;
      funct3_q  <= 3'h0;
      off_q     <= 2'h0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 32'h0;
      if (take) begin
        psel     <= 1'b1;
        paddr    <= {alu_data[31:2], 2'b00};
        pwrite   <= req_we;
        pstrb    <= st_strb;
        pwdata   <= st_wdata;
        funct3_q <= req_funct3;
        off_q    <= alu_data[1:0];
      end
      if (state == SETUP) begin
        penable  <= 1'b1;
        wait_cnt <= '0;
      end
      if ((state == ACCESS) && !pready && !abort) wait_cnt <= wait_cnt + 1'b1;
      if (done || abort) begin
        psel      <= 1'b0;
        penable   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= abort | pslverr;
        rsp_data  <= (abort || pslverr || pwrite) ? 32'h0 : ld_data;
      end
      if (state == ERR) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule
